// File: rtl/spi_pkg.sv
// Shared types and config-field offsets for the multi-slave SPI master.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      TRANSFER,
      HOLD,
      DONE
   } spi_state_e;

   // Encoded as {cpol, cpha}
   typedef enum logic [1:0] {
      MODE0,
      MODE1,
      MODE2,
      MODE3
   } spi_mode_e;

   localparam int CFG_CPOL   = 0;
   localparam int CFG_CPHA   = 1;
   localparam int CFG_LSB    = 2;
   localparam int CFG_SS_LSB = 3;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider: ticks every clk_div+1 cycles while enabled and
// classifies permitted SCK edges as leading or trailing.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             edge_en,
   input  logic [DIV_W-1:0] clk_div,
   output logic             tick,
   output logic             lead_stb,
   output logic             trail_stb
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_comb begin
      tick      = en && (cnt_q == clk_div);
      lead_stb  = tick && edge_en && !phase_q;
      trail_stb = tick && edge_en && phase_q;
      cnt_d     = '0;
      phase_d   = 1'b0;
      if (en) begin
         cnt_d   = tick ? '0 : cnt_q + 1'b1;
         phase_d = phase_q ^ (tick && edge_en);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: one DATA_W-bit word per transfer, any CPOL/CPHA,
// per-transfer bit order, divider and slave select.
module spi_master_mc
   import spi_pkg::*;
#(
   parameter int  DATA_W = 8,
   parameter int  NUM_SS = 3,
   parameter int  DIV_W  = 8,
   localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
   localparam int CFG_W  = 3 + SS_W + DIV_W
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CFG_W-1:0]  i_data_config,
   input  logic              i_trans_en,
   input  logic              i_miso,
   output logic              o_mosi,
   output logic              o_sck,
   output logic [NUM_SS-1:0] o_ss_n,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy,
   output logic              o_interrupt,
   output logic              o_err
);

   localparam int               CNT_W     = $clog2(2 * DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);

   spi_state_e        state_q, state_d;
   spi_mode_e         mode_q, mode_d;
   logic              lsb_q, lsb_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              sck_q, sck_d, mosi_q, mosi_d;
   logic              busy_q, busy_d, intr_q, intr_d, err_q, err_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;

   logic              cfg_cpol, cfg_cpha, cfg_lsb, req_ok;
   logic [SS_W-1:0]   cfg_ss;
   logic [DIV_W-1:0]  cfg_div;
   logic              cpha, clk_en, edge_en, edges_done;
   logic              tick, lead_stb, trail_stb, sample, shift;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   assign cfg_cpol = i_data_config[CFG_CPOL];
   assign cfg_cpha = i_data_config[CFG_CPHA];
   assign cfg_lsb  = i_data_config[CFG_LSB];
   assign cfg_ss   = i_data_config[CFG_SS_LSB +: SS_W];
   assign cfg_div  = i_data_config[CFG_SS_LSB + SS_W +: DIV_W];
   assign req_ok   = i_trans_en && (int'(cfg_ss) < NUM_SS);

   assign cpha       = (mode_q == MODE1) || (mode_q == MODE3);
   assign edges_done = (edge_cnt_q == LAST_EDGE);
   assign clk_en     = (state_q == SETUP) || (state_q == TRANSFER) || (state_q == HOLD);
   // The end of SETUP produces the first edge; TRANSFER stops edging after 2*DATA_W.
   assign edge_en    = (state_q == SETUP) || ((state_q == TRANSFER) && !edges_done);

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk       (i_sys_clk),
      .rst_n     (i_sys_rst),
      .en        (clk_en),
      .edge_en   (edge_en),
      .clk_div   (div_q),
      .tick      (tick),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb)
   );

   // CPHA=0 already put bit 0 out at accept, so the final trailing edge has nothing to shift.
   assign sample = cpha ? trail_stb : lead_stb;
   assign shift  = cpha ? lead_stb
                        : (trail_stb && (edge_cnt_q != LAST_EDGE - 1'b1));

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (req_ok) state_d = SETUP;
         SETUP:    if (tick) state_d = TRANSFER;
         TRANSFER: if (tick && edges_done) state_d = HOLD;
         HOLD:     if (tick) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      mode_d     = mode_q;
      lsb_d      = lsb_q;
      div_d      = div_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      data_d     = data_q;
      edge_cnt_d = edge_cnt_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      ss_n_d     = ss_n_q;
      busy_d     = busy_q;
      intr_d     = 1'b0;
      err_d      = 1'b0;

      if (state_q == IDLE && i_trans_en) begin
         if (req_ok) begin
            mode_d     = spi_mode_e'({cfg_cpol, cfg_cpha});
            lsb_d      = cfg_lsb;
            div_d      = cfg_div;
            rx_d       = '0;
            edge_cnt_d = '0;
            sck_d      = cfg_cpol;
            busy_d     = 1'b1;
            for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = (int'(cfg_ss) != i);
            if (!cfg_cpha) begin
               mosi_d = first_bit(i_data, cfg_lsb);
               tx_d   = shift_tx(i_data, cfg_lsb);
            end else begin
               tx_d   = i_data;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (lead_stb || trail_stb) begin
         sck_d      = !sck_q;
         edge_cnt_d = edge_cnt_q + 1'b1;
      end
      if (sample) rx_d = lsb_q ? {i_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], i_miso};
      if (shift) begin
         mosi_d = first_bit(tx_q, lsb_q);
         tx_d   = shift_tx(tx_q, lsb_q);
      end

      if (state_q == HOLD && tick) begin
         data_d = rx_q;
         intr_d = 1'b1;
         ss_n_d = '1;
      end
      if (state_q == DONE) busy_d = 1'b0;
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         mode_q     <= MODE0;
         lsb_q      <= 1'b0;
         div_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_q     <= '0;
         edge_cnt_q <= '0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         ss_n_q     <= '1;
         busy_q     <= 1'b0;
         intr_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         lsb_q      <= lsb_d;
         div_q      <= div_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         data_q     <= data_d;
         edge_cnt_q <= edge_cnt_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
         busy_q     <= busy_d;
         intr_q     <= intr_d;
         err_q      <= err_d;
      end
   end

   assign o_mosi      = mosi_q;
   assign o_sck       = sck_q;
   assign o_ss_n      = ss_n_q;
   assign o_data      = data_q;
   assign o_busy      = busy_q;
   assign o_interrupt = intr_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc with a behavioural SPI slave on the bus.
module tb_spi_master_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_in = '0;
   logic [12:0] cfg_in = '0;
   logic        trans_en = 1'b0;
   logic        miso = 1'b0;
   logic        mosi, sck, busy, intr, err;
   logic [2:0]  ss_n;
   logic [7:0]  data_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_master_mc #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) dut (
      .i_sys_clk     (clk),
      .i_sys_rst     (rst_n),
      .i_data        (data_in),
      .i_data_config (cfg_in),
      .i_trans_en    (trans_en),
      .i_miso        (miso),
      .o_mosi        (mosi),
      .o_sck         (sck),
      .o_ss_n        (ss_n),
      .o_data        (data_out),
      .o_busy        (busy),
      .o_interrupt   (intr),
      .o_err         (err)
   );

   // Slave: drives its word on miso, captures mosi, in the configured mode.
   logic [7:0] s_word = '0, s_sh = '0, s_rx = '0;
   logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
   logic [1:0] s_sel = '0;
   logic       prev_sck = 1'b0, prev_sel = 1'b0;
   logic       sel_now;

   assign sel_now = !ss_n[s_sel];

   function automatic logic s_first(input logic [7:0] w, input logic lsb);
      return lsb ? w[0] : w[7];
   endfunction

   function automatic logic [7:0] s_shift(input logic [7:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   always @(negedge clk) begin
      prev_sck <= sck;
      prev_sel <= sel_now;
      if (sel_now && !prev_sel) begin
         s_rx <= '0;
         if (!s_cpha) begin
            miso <= s_first(s_word, s_lsb);
            s_sh <= s_shift(s_word, s_lsb);
         end else begin
            s_sh <= s_word;
         end
      end else if (sel_now && (sck != prev_sck)) begin
         if ((sck != s_cpol) ^ s_cpha)
            s_rx <= s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
         else begin
            miso <= s_first(s_sh, s_lsb);
            s_sh <= s_shift(s_sh, s_lsb);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] mk_cfg(input logic [7:0] div, input logic [1:0] ss,
                                          input logic lsb, input logic cpha, input logic cpol);
      return {div, ss, lsb, cpha, cpol};
   endfunction

   // One full transfer; cycle 1 is the cycle right after the accepting edge.
   task automatic do_xfer(input string tag, input logic [12:0] cfg, input logic [7:0] d,
                          input logic [7:0] sw, input bit meddle, input int exp_cyc,
                          input logic [2:0] exp_ss);
      int          icyc;
      logic [2:0]  ss_mid;
      @(negedge clk);
      s_word = sw; s_cpol = cfg[0]; s_cpha = cfg[1]; s_lsb = cfg[2]; s_sel = cfg[4:3];
      data_in = d; cfg_in = cfg; trans_en = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
      trans_en = 1'b0;
      icyc = -1;
      ss_mid = 3'b000;
      for (int c = 1; c <= 200; c++) begin
         if (c == 5) ss_mid = ss_n;
         if (meddle && c == 10) begin
            data_in = 8'hFF; cfg_in[0] = ~cfg[0]; trans_en = 1'b1;
         end
         if (meddle && c == 11) trans_en = 1'b0;
         if (meddle && c == 12) trans_en = 1'b1;
         if (meddle && c == 13) trans_en = 1'b0;
         if (intr) begin
            icyc = c;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_int_cycle"}, 32'(icyc), 32'(exp_cyc));
      chk({tag, "_ss_mid"}, 32'(ss_mid), 32'(exp_ss));
      chk({tag, "_rx_data"}, 32'(data_out), 32'(sw));
      chk({tag, "_mosi_word"}, 32'(s_rx), 32'(d));
      chk({tag, "_ss_done"}, 32'(ss_n), 32'h7);
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      chk({tag, "_sck_idle"}, 32'(sck), 32'(cfg[0]));
      @(posedge clk); #1;
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_int_pulse"}, 32'(intr), 32'd0);
   endtask

   initial begin
      int n_int, gap, run;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_ss", 32'(ss_n), 32'h7);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_int", 32'(intr), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Mode 0, MSB first, T=2 -> interrupt at cycle 37
      do_xfer("m0", mk_cfg(8'd1, 2'd2, 1'b0, 1'b0, 1'b0), 8'hA5, 8'h3C, 1'b0, 37, 3'b011);

      // Mode 3, LSB first, T=1 -> interrupt at cycle 19
      do_xfer("m3", mk_cfg(8'd0, 2'd0, 1'b1, 1'b1, 1'b1), 8'h81, 8'hC3, 1'b0, 19, 3'b110);

      // Rejected request: ss_sel beyond NUM_SS
      @(negedge clk);
      cfg_in = mk_cfg(8'd0, 2'd3, 1'b0, 1'b0, 1'b0);
      trans_en = 1'b1;
      @(posedge clk); #1;
      trans_en = 1'b0;
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      chk("rej_ss", 32'(ss_n), 32'h7);
      chk("rej_sck", 32'(sck), 32'd1);
      @(posedge clk); #1;
      chk("rej_err_clr", 32'(err), 32'd0);
      chk("rej_busy2", 32'(busy), 32'd0);

      // Back-to-back with i_trans_en held high
      @(negedge clk);
      s_word = 8'h96; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_sel = 2'd1;
      data_in = 8'h3C; cfg_in = mk_cfg(8'd0, 2'd1, 1'b0, 1'b0, 1'b0); trans_en = 1'b1;
      @(posedge clk); #1;
      n_int = 0; gap = 0; run = 0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 25) trans_en = 1'b0;
         if (intr) n_int++;
         if (ss_n[1]) run++;
         else begin
            if (run != 0) gap = run;
            run = 0;
         end
         @(posedge clk); #1;
      end
      chk("b2b_ints", 32'(n_int), 32'd2);
      chk("b2b_gap", 32'(gap), 32'd2);
      chk("b2b_data", 32'(data_out), 32'h96);
      chk("b2b_mosi", 32'(s_rx), 32'h3C);
      chk("b2b_idle", 32'(busy), 32'd0);

      // Reset mid-transfer (cpol=1, all-ones word so sck/mosi are 1 when hit)
      @(negedge clk);
      s_word = 8'h00; s_cpol = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0; s_sel = 2'd2;
      data_in = 8'hFF; cfg_in = mk_cfg(8'd1, 2'd2, 1'b0, 1'b0, 1'b1); trans_en = 1'b1;
      @(posedge clk); #1;
      trans_en = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk);
      chk("abort_mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_sck", 32'(sck), 32'd0);
      chk("abort_ss", 32'(ss_n), 32'h7);
      chk("abort_mosi", 32'(mosi), 32'd0);
      chk("abort_data", 32'(data_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_int", 32'(intr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_int = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (intr) n_int++;
      end
      chk("abort_no_int", 32'(n_int), 32'd0);
      do_xfer("post", mk_cfg(8'd1, 2'd2, 1'b0, 1'b0, 1'b0), 8'h5A, 8'hE7, 1'b0, 37, 3'b011);

      // Inputs disturbed while busy
      do_xfer("busy_in", mk_cfg(8'd1, 2'd1, 1'b0, 1'b0, 1'b0), 8'h69, 8'h1E, 1'b1, 37, 3'b101);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
